// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the PMIPSL0 16-bit datapath.
// Holds the PC, presents it to the instruction ROM, and loads the IF/ID
// register according to the controller's PCControl command.
module fetch_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  PCControl,
  input  logic        JumpTaken,
  input  logic        BranchTaken,
  input  logic [15:0] JumpAddr,
  input  logic [15:0] BranchAddr,
  input  logic [15:0] IMemData,
  output logic [15:0] IMemAddr,
  output logic [15:0] PC,
  output logic [15:0] IFID_Instr,
  output logic [15:0] IFID_PCPlus2,
  output logic [3:0]  OpCode,
  output logic        IFID_Valid,
  output logic        AlignErr,
  output logic [15:0] InstrCount
);

  localparam logic [1:0] CMD_STALL    = 2'd0;
  localparam logic [1:0] CMD_INC      = 2'd1;
  localparam logic [1:0] CMD_CONDLOAD = 2'd2;

  // Halfword alignment: an instruction address must have bit 0 clear.
  function automatic logic is_odd(input logic [15:0] addr);
    return addr[0];
  endfunction

  logic [15:0] pc_q,    pc_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] pcp2_q,  pcp2_d;
  logic        valid_q, valid_d;
  logic        align_q, align_d;
  logic [15:0] cnt_q,   cnt_d;
  logic [15:0] pc_plus2_s;
  logic [15:0] target_s;
  logic        load_s;

  assign pc_plus2_s = pc_q + 16'd2;

  // Select the redirect target; jump outranks branch, only on CondLoad.
  always_comb begin
    target_s = pc_q;
    load_s   = 1'b0;
    if (PCControl == CMD_CONDLOAD) begin
      if (JumpTaken) begin
        target_s = JumpAddr;
        load_s   = 1'b1;
      end else if (BranchTaken) begin
        target_s = BranchAddr;
        load_s   = 1'b1;
      end else begin
        target_s = pc_q;
        load_s   = 1'b0;
      end
    end else begin
      target_s = pc_q;
      load_s   = 1'b0;
    end
  end

  // Next-state logic for PC, IF/ID and the fetch counter.
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    pcp2_d  = pcp2_q;
    valid_d = valid_q;
    align_d = align_q;
    cnt_d   = cnt_q;
    case (PCControl)
      CMD_STALL: begin
        pc_d = pc_q;
      end
      CMD_INC: begin
        instr_d = IMemData;
        pcp2_d  = pc_plus2_s;
        valid_d = 1'b1;
        pc_d    = pc_plus2_s;
        if (cnt_q != 16'hFFFF) begin
          cnt_d = cnt_q + 16'd1;
        end else begin
          cnt_d = cnt_q;
        end
      end
      CMD_CONDLOAD: begin
        if (load_s) begin
          // Odd targets are truncated to the halfword and flagged stickily.
          pc_d = {target_s[15:1], 1'b0};
          if (is_odd(target_s)) begin
            align_d = 1'b1;
          end else begin
            align_d = align_q;
          end
        end else begin
          pc_d = pc_q;
        end
      end
      default: begin
        // Reserved command behaves as a stall.
        pc_d = pc_q;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      pc_q    <= RESET_PC;
      instr_q <= 16'h0000;
      pcp2_q  <= 16'h0000;
      valid_q <= 1'b0;
      align_q <= 1'b0;
      cnt_q   <= 16'h0000;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pcp2_q  <= pcp2_d;
      valid_q <= valid_d;
      align_q <= align_d;
      cnt_q   <= cnt_d;
    end
  end

  assign IMemAddr     = pc_q;
  assign PC           = pc_q;
  assign IFID_Instr   = instr_q;
  assign IFID_PCPlus2 = pcp2_q;
  assign OpCode       = instr_q[15:12];
  assign IFID_Valid   = valid_q;
  assign AlignErr     = align_q;
  assign InstrCount   = cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage with a small combinational ROM model.
module tb_fetch_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  PCControl;
  logic        JumpTaken, BranchTaken;
  logic [15:0] JumpAddr, BranchAddr;
  logic [15:0] IMemData, IMemAddr, PC, IFID_Instr, IFID_PCPlus2, InstrCount;
  logic [3:0]  OpCode;
  logic        IFID_Valid, AlignErr;

  int vectors = 0;
  int miscompares = 0;

  fetch_stage #(.RESET_PC(16'h0000)) dut (
    .clock(clock), .reset(reset), .PCControl(PCControl),
    .JumpTaken(JumpTaken), .BranchTaken(BranchTaken),
    .JumpAddr(JumpAddr), .BranchAddr(BranchAddr),
    .IMemData(IMemData), .IMemAddr(IMemAddr), .PC(PC),
    .IFID_Instr(IFID_Instr), .IFID_PCPlus2(IFID_PCPlus2),
    .OpCode(OpCode), .IFID_Valid(IFID_Valid), .AlignErr(AlignErr),
    .InstrCount(InstrCount)
  );

  always #5 clock = ~clock;

  // Instruction ROM contents: two fixed words, a pattern elsewhere.
  function automatic logic [15:0] rom(input logic [15:0] a);
    if (a == 16'h0000)      return 16'h0123;
    else if (a == 16'h0002) return 16'h1456;
    else                    return {4'hE, a[11:0]};
  endfunction

  assign IMemData = rom(IMemAddr);

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply one command across one rising edge, then settle before checking.
  task automatic step(input logic rst, input logic [1:0] ctl, input logic jt,
                      input logic bt, input logic [15:0] ja, input logic [15:0] ba);
    reset = rst; PCControl = ctl; JumpTaken = jt; BranchTaken = bt;
    JumpAddr = ja; BranchAddr = ba;
    @(posedge clock);
    #1;
  endtask

  initial begin
    // Reset held for two cycles while Inc is requested.
    step(1'b0, 2'd1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    step(1'b0, 2'd1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    chk("rst_pc",    PC,                 16'h0000);
    chk("rst_valid", {15'd0, IFID_Valid}, 16'h0000);
    chk("rst_cnt",   InstrCount,         16'h0000);
    chk("rst_align", {15'd0, AlignErr},   16'h0000);
    chk("rst_instr", IFID_Instr,         16'h0000);

    // First Inc/Stall/Stall/CondLoad sequence.
    step(1'b1, 2'd1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    chk("f1_instr",  IFID_Instr,         16'h0123);
    chk("f1_op",     {12'd0, OpCode},     16'h0000);
    chk("f1_pcp2",   IFID_PCPlus2,       16'h0002);
    chk("f1_valid",  {15'd0, IFID_Valid}, 16'h0001);
    chk("f1_pc",     PC,                 16'h0002);
    step(1'b1, 2'd0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    step(1'b1, 2'd0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    chk("stall_pc",  PC,                 16'h0002);
    step(1'b1, 2'd2, 1'b0, 1'b0, 16'h0080, 16'h0090);
    chk("cl_none_pc", PC,                16'h0002);
    chk("cl_none_cnt", InstrCount,       16'h0001);

    // Second sequence.
    step(1'b1, 2'd1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    chk("f2_instr",  IFID_Instr,         16'h1456);
    chk("f2_op",     {12'd0, OpCode},     16'h0001);
    chk("f2_pc",     PC,                 16'h0004);
    chk("f2_cnt",    InstrCount,         16'h0002);
    chk("f2_pcp2",   IFID_PCPlus2,       16'h0004);
    chk("f2_imaddr", IMemAddr,           16'h0004);
    step(1'b1, 2'd0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    step(1'b1, 2'd0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    step(1'b1, 2'd2, 1'b0, 1'b0, 16'h0000, 16'h0000);

    // Branch taken, then jump beats branch.
    step(1'b1, 2'd2, 1'b0, 1'b1, 16'h0200, 16'h0040);
    chk("br_pc",     PC,                 16'h0040);
    chk("br_instr",  IFID_Instr,         16'h1456);
    step(1'b1, 2'd2, 1'b1, 1'b1, 16'h0100, 16'h0040);
    chk("jmp_pc",    PC,                 16'h0100);
    chk("jmp_instr", IFID_Instr,         16'h1456);
    chk("jmp_pcp2",  IFID_PCPlus2,       16'h0004);
    chk("jmp_cnt",   InstrCount,         16'h0002);
    chk("jmp_align", {15'd0, AlignErr},   16'h0000);

    // Misaligned jump target, flag must persist.
    step(1'b1, 2'd2, 1'b1, 1'b0, 16'h0033, 16'h0000);
    chk("mis_pc",    PC,                 16'h0032);
    chk("mis_align", {15'd0, AlignErr},   16'h0001);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 2'd0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    end
    chk("mis_sticky", {15'd0, AlignErr},  16'h0001);
    chk("mis_hold_pc", PC,               16'h0032);

    // Wrap of PC from FFFE.
    step(1'b1, 2'd2, 1'b1, 1'b0, 16'hFFFE, 16'h0000);
    chk("wr_load",   PC,                 16'hFFFE);
    step(1'b1, 2'd1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    chk("wr_pc",     PC,                 16'h0000);
    chk("wr_instr",  IFID_Instr,         16'hEFFE);
    chk("wr_op",     {12'd0, OpCode},     16'h000E);
    chk("wr_pcp2",   IFID_PCPlus2,       16'h0000);
    chk("wr_cnt",    InstrCount,         16'h0003);

    // Reserved command with a jump pending: nothing moves.
    step(1'b1, 2'd3, 1'b1, 1'b1, 16'h0200, 16'h0300);
    chk("rsv_pc",    PC,                 16'h0000);
    chk("rsv_cnt",   InstrCount,         16'h0003);
    chk("rsv_instr", IFID_Instr,         16'hEFFE);
    // CondLoad with nothing taken holds.
    step(1'b1, 2'd2, 1'b0, 1'b0, 16'h0200, 16'h0300);
    chk("cl_hold_pc", PC,                16'h0000);
    // Inc ignores a pending jump.
    step(1'b1, 2'd1, 1'b1, 1'b0, 16'h0300, 16'h0000);
    chk("inc_jmp_pc", PC,                16'h0002);
    chk("inc_jmp_instr", IFID_Instr,     16'h0123);
    chk("inc_jmp_cnt", InstrCount,       16'h0004);

    // Reset during a CondLoad with jump: jump discarded.
    step(1'b0, 2'd2, 1'b1, 1'b0, 16'h0300, 16'h0000);
    chk("mr_pc",     PC,                 16'h0000);
    chk("mr_align",  {15'd0, AlignErr},   16'h0000);
    chk("mr_cnt",    InstrCount,         16'h0000);
    chk("mr_valid",  {15'd0, IFID_Valid}, 16'h0000);
    chk("mr_instr",  IFID_Instr,         16'h0000);
    step(1'b1, 2'd1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    chk("post_instr", IFID_Instr,        16'h0123);
    chk("post_pc",   PC,                 16'h0002);
    chk("post_cnt",  InstrCount,         16'h0001);
    chk("post_valid", {15'd0, IFID_Valid}, 16'h0001);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage for the PMIPSL0 16-bit datapath. Holds the program counter, reads the instruction memory, and loads the IF/ID pipeline register. It acts on the controller's PCControl command each cycle: Stall, Inc, or CondLoad. It supplies OpCode back to the controller and accepts jump and branch-taken targets from the memory-access stage.

## Interface
- RESET_PC, 16'h0000, PC value loaded on reset; bit 0 must be 0.
- clock  input  1  rising-edge system clock.
- reset  input  1  synchronous, active-low reset (0 = reset).
- PCControl  input  2  0 = Stall, 1 = Inc, 2 = CondLoad, 3 = reserved.
- JumpTaken  input  1  memory-access stage reports a jump.
- BranchTaken  input  1  memory-access stage reports a taken branch (Branch & ALUzero).
- JumpAddr  input  16  jump target.
- BranchAddr  input  16  branch target.
- IMemData  input  16  instruction word at IMemAddr; combinational (asynchronous) ROM.
- IMemAddr  output  16  equals PC; combinational.
- PC  output  16  current program counter.
- IFID_Instr  output  16  registered instruction.
- IFID_PCPlus2  output  16  registered PC+2 of that instruction.
- OpCode  output  4  IFID_Instr[15:12]; feeds the controller.
- IFID_Valid  output  1  IF/ID holds a fetched instruction.
- AlignErr  output  1  sticky flag: an odd target address was loaded.
- InstrCount  output  16  number of Inc commands since reset; saturating.

## Operation
- All state updates occur on the rising edge of clock. When reset = 0 at an edge: PC = RESET_PC, IFID_Instr = 0, IFID_PCPlus2 = 0, IFID_Valid = 0, AlignErr = 0, InstrCount = 0. Reset overrides every command.
- Stall (0): PC, IF/ID, and the counter hold.
- Inc (1):
  - IFID_Instr <= IMemData.
  - IFID_PCPlus2 <= PC+2.
  - IFID_Valid <= 1.
  - PC <= PC+2, modulo 2^16 (16'hFFFE wraps to 16'h0000).
  - InstrCount <= InstrCount+1, saturating at 16'hFFFF.
- CondLoad (2):
  - IF/ID and InstrCount hold.
  - If JumpTaken: PC <= JumpAddr.
  - Else if BranchTaken: PC <= BranchAddr.
  - Else PC holds.
  - Jump has priority when JumpTaken and BranchTaken are both asserted.
- Selected target with bit 0 = 1: PC loads the target with bit 0 forced to 0, and AlignErr <= 1. AlignErr stays set until reset.
- Reserved (3): treated as Stall; no state changes.
- JumpTaken, BranchTaken, and the target addresses are ignored unless PCControl = 2.

## Timing
- IMemAddr and OpCode are purely combinational from registers; there is no combinational path from any input to any output.
- Fetch latency is 1 cycle: the word at PC appears on IFID_Instr and OpCode in the cycle after an Inc edge.
- The normal controller cadence is 4 cycles per instruction: Inc, Stall, Stall, CondLoad. The new PC after a CondLoad is visible on IMemAddr in the following cycle, which is the controller's next Inc state.
- If reset is deasserted mid-sequence, the next non-reset edge acts on that cycle's PCControl; no extra bubble is inserted.

## Test plan
- Reset: drive reset = 0 for 2 cycles with PCControl = 1 → PC = 0, IFID_Valid = 0, InstrCount = 0, AlignErr = 0.
- Sequential fetch: ROM[0] = 16'h0123, ROM[2] = 16'h1456; run 2 full Inc/Stall/Stall/CondLoad sequences with no taken signals → after the first Inc edge: IFID_Instr = 16'h0123, OpCode = 0, IFID_PCPlus2 = 2; after the second Inc edge: IFID_Instr = 16'h1456, OpCode = 1, PC = 4, InstrCount = 2.
- Branch vs jump priority:
  - CondLoad with BranchTaken = 1, BranchAddr = 16'h0040 → PC = 16'h0040.
  - CondLoad with both taken, JumpAddr = 16'h0100, BranchAddr = 16'h0040 → PC = 16'h0100.
  - IF/ID is unchanged in both cases.
- Misaligned target: CondLoad with JumpTaken = 1, JumpAddr = 16'h0033 → PC = 16'h0032 and AlignErr = 1; AlignErr is still 1 after 10 further cycles.
- Wrap and reserved command:
  - PC = 16'hFFFE, Inc → PC = 16'h0000.
  - PCControl = 3 with JumpTaken = 1 → no state changes.
  - PCControl = 2 with neither taken signal → PC holds.
- Reset mid-operation: pull reset low in a CondLoad cycle with JumpTaken = 1 → PC = RESET_PC and the jump is discarded; after release, an Inc fetches ROM[RESET_PC].
